// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage:
//   alu_op_t      4-bit ALU operation codes consumed by the ALU
//   OP_*          RV32I major opcode constants (instruction[6:0])
//   src_a_sel_t   SrcA source select (rs1 / pc / zero)
//   src_b_sel_t   SrcB source select (rs2 / imm / constant 4)
//   arith_op()    funct3/funct7_5 map shared by R-type and I-ALU formats
//   branch_op()   funct3 map for conditional branches
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND     = 4'b0000,
      ALU_OR      = 4'b0001,
      ALU_ADD     = 4'b0010,
      ALU_XOR     = 4'b0011,
      ALU_SLL     = 4'b0100,
      ALU_SRL     = 4'b0101,
      ALU_SUB     = 4'b0110,
      ALU_SRA     = 4'b0111,
      ALU_BEQ     = 4'b1000,
      ALU_BLT     = 4'b1001,
      ALU_BGE     = 4'b1010,
      ALU_BNE     = 4'b1011,
      ALU_SLT     = 4'b1100,
      ALU_ILLEGAL = 4'b1111
   } alu_op_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      SRCA_RS1  = 2'd0,
      SRCA_PC   = 2'd1,
      SRCA_ZERO = 2'd2
   } src_a_sel_t;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'd0,
      SRCB_IMM  = 2'd1,
      SRCB_FOUR = 2'd2
   } src_b_sel_t;

   // For I-ALU, bit 30 is part of the immediate except for shifts, so it
   // only selects SUB in register form and SRA/SRL in both forms. A set
   // bit 30 on SLLI is a malformed shift encoding.
   function automatic alu_op_t arith_op(input logic [2:0] funct3,
                                        input logic       funct7_5,
                                        input logic       is_reg);
      alu_op_t op;
      case (funct3)
         3'b000:  op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = (!is_reg && funct7_5) ? ALU_ILLEGAL : ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b100:  op = ALU_XOR;
         3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ILLEGAL;
      endcase
      return op;
   endfunction

   function automatic alu_op_t branch_op(input logic [2:0] funct3);
      alu_op_t op;
      case (funct3)
         3'b000:  op = ALU_BEQ;
         3'b001:  op = ALU_BNE;
         3'b100:  op = ALU_BLT;
         3'b101:  op = ALU_BGE;
         default: op = ALU_ILLEGAL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational RV32I decode for the ALU issue stage.
// Ports:
//   i_opcode, i_funct3, i_funct7_5   instruction fields
//   o_operation                      ALU operation code
//   o_src_a_sel, o_src_b_sel         operand source selects
//   o_regwrite                       format writes rd (before the rd!=0 gate)
//   o_is_branch                      conditional branch
//   o_illegal                        unsupported encoding
// ---------------------------------------------------------------------------
module alu_op_decoder
   import alu_pkg::*;
(
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_funct3,
   input  logic        i_funct7_5,
   output alu_op_t     o_operation,
   output src_a_sel_t  o_src_a_sel,
   output src_b_sel_t  o_src_b_sel,
   output logic        o_regwrite,
   output logic        o_is_branch,
   output logic        o_illegal
);

   always_comb begin
      o_operation = ALU_ILLEGAL;
      o_src_a_sel = SRCA_RS1;
      o_src_b_sel = SRCB_RS2;
      o_regwrite  = 1'b0;
      o_is_branch = 1'b0;
      case (i_opcode)
         OP_R: begin
            o_operation = arith_op(i_funct3, i_funct7_5, 1'b1);
            o_regwrite  = 1'b1;
         end
         OP_IMM: begin
            o_operation = arith_op(i_funct3, i_funct7_5, 1'b0);
            o_src_b_sel = SRCB_IMM;
            o_regwrite  = 1'b1;
         end
         OP_LOAD: begin
            o_operation = ALU_ADD;
            o_src_b_sel = SRCB_IMM;
            o_regwrite  = 1'b1;
         end
         OP_STORE: begin
            o_operation = ALU_ADD;
            o_src_b_sel = SRCB_IMM;
         end
         OP_BRANCH: begin
            o_operation = branch_op(i_funct3);
            o_is_branch = 1'b1;
         end
         OP_JAL, OP_JALR: begin
            // ALU produces the link value pc+4; the target is computed elsewhere
            o_operation = ALU_ADD;
            o_src_a_sel = SRCA_PC;
            o_src_b_sel = SRCB_FOUR;
            o_regwrite  = 1'b1;
         end
         OP_LUI: begin
            o_operation = ALU_ADD;
            o_src_a_sel = SRCA_ZERO;
            o_src_b_sel = SRCB_IMM;
            o_regwrite  = 1'b1;
         end
         OP_AUIPC: begin
            o_operation = ALU_ADD;
            o_src_a_sel = SRCA_PC;
            o_src_b_sel = SRCB_IMM;
            o_regwrite  = 1'b1;
         end
         default: begin
         end
      endcase
      // A bad funct field inside a known format must neither write back
      // nor be treated as a branch.
      if (o_operation == ALU_ILLEGAL) begin
         o_regwrite  = 1'b0;
         o_is_branch = 1'b0;
      end
   end

   assign o_illegal = (o_operation == ALU_ILLEGAL);

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX issue stage: decodes the ALU operation, forwards rs1/rs2 from
// EX/MEM and MEM/WB, selects SrcA/SrcB and holds the result in a
// single-entry valid/ready pipeline register.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_valid/in_ready                   upstream handshake
//   opcode, funct3, funct7_5            instruction fields
//   rs1_addr, rs2_addr, rd_addr         register indices
//   rs1_data, rs2_data, imm, pc         register reads, immediate, PC
//   exmem_*/memwb_*                     forwarding sources
//   flush                               kill held and incoming instruction
//   out_valid/out_ready                 downstream handshake
//   SrcA, SrcB, Operation               ALU inputs
//   store_data, out_rd                  forwarded rs2, destination
//   out_regwrite, out_is_branch, illegal status flags
// ---------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int OPCODE_LENGTH  = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [6:0]                opcode,
   input  logic [2:0]                funct3,
   input  logic                      funct7_5,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0]     rs1_data,
   input  logic [DATA_WIDTH-1:0]     rs2_data,
   input  logic [DATA_WIDTH-1:0]     imm,
   input  logic [DATA_WIDTH-1:0]     pc,
   input  logic                      exmem_regwrite,
   input  logic                      memwb_regwrite,
   input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
   input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
   input  logic [DATA_WIDTH-1:0]     exmem_result,
   input  logic [DATA_WIDTH-1:0]     memwb_result,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     SrcA,
   output logic [DATA_WIDTH-1:0]     SrcB,
   output logic [OPCODE_LENGTH-1:0]  Operation,
   output logic [DATA_WIDTH-1:0]     store_data,
   output logic [REG_ADDR_WIDTH-1:0] out_rd,
   output logic                      out_regwrite,
   output logic                      out_is_branch,
   output logic                      illegal
);

   // decode
   alu_op_t    w_dec_op;
   src_a_sel_t w_src_a_sel;
   src_b_sel_t w_src_b_sel;
   logic       w_dec_regwrite;
   logic       w_dec_is_branch;
   logic       w_dec_illegal;

   alu_op_decoder u_decoder (
      .i_opcode    (opcode),
      .i_funct3    (funct3),
      .i_funct7_5  (funct7_5),
      .o_operation (w_dec_op),
      .o_src_a_sel (w_src_a_sel),
      .o_src_b_sel (w_src_b_sel),
      .o_regwrite  (w_dec_regwrite),
      .o_is_branch (w_dec_is_branch),
      .o_illegal   (w_dec_illegal)
   );

   // forwarding: index 0 is rs1, index 1 is rs2
   logic [REG_ADDR_WIDTH-1:0] w_src_addr [2];
   logic [DATA_WIDTH-1:0]     w_src_rf   [2];
   logic [DATA_WIDTH-1:0]     w_src_fwd  [2];

   assign w_src_addr[0] = rs1_addr;
   assign w_src_addr[1] = rs2_addr;
   assign w_src_rf[0]   = rs1_data;
   assign w_src_rf[1]   = rs2_data;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic w_hit_exmem;
         logic w_hit_memwb;
         // x0 is hardwired to zero, so a pending write to it never forwards
         assign w_hit_exmem = exmem_regwrite && (w_src_addr[gi] != '0) &&
                              (exmem_rd == w_src_addr[gi]);
         assign w_hit_memwb = memwb_regwrite && (w_src_addr[gi] != '0) &&
                              (memwb_rd == w_src_addr[gi]);
         // EX/MEM holds the younger result, so it takes precedence
         assign w_src_fwd[gi] = w_hit_exmem ? exmem_result :
                                w_hit_memwb ? memwb_result :
                                              w_src_rf[gi];
      end
   endgenerate

   // operand selection
   logic [DATA_WIDTH-1:0] w_src_a;
   logic [DATA_WIDTH-1:0] w_src_b;

   always_comb begin
      w_src_a = w_src_fwd[0];
      case (w_src_a_sel)
         SRCA_PC:   w_src_a = pc;
         SRCA_ZERO: w_src_a = '0;
         default:   w_src_a = w_src_fwd[0];
      endcase
   end

   always_comb begin
      w_src_b = w_src_fwd[1];
      case (w_src_b_sel)
         SRCB_IMM:  w_src_b = imm;
         SRCB_FOUR: w_src_b = DATA_WIDTH'(32'd4);
         default:   w_src_b = w_src_fwd[1];
      endcase
   end

   logic w_regwrite;
   assign w_regwrite = w_dec_regwrite && (rd_addr != '0);

   // pipeline register
   logic                      r_valid;
   logic [DATA_WIDTH-1:0]     r_src_a;
   logic [DATA_WIDTH-1:0]     r_src_b;
   logic [DATA_WIDTH-1:0]     r_store_data;
   logic [OPCODE_LENGTH-1:0]  r_operation;
   logic [REG_ADDR_WIDTH-1:0] r_rd;
   logic                      r_regwrite;
   logic                      r_is_branch;
   logic                      r_illegal;
   logic                      w_capture;

   assign in_ready  = !r_valid || out_ready;
   assign w_capture = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid      <= 1'b0;
         r_src_a      <= '0;
         r_src_b      <= '0;
         r_store_data <= '0;
         r_operation  <= '0;
         r_rd         <= '0;
         r_regwrite   <= 1'b0;
         r_is_branch  <= 1'b0;
         r_illegal    <= 1'b0;
      end else if (flush) begin
         // payload is left as-is; only the valid bit is killed
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid      <= 1'b1;
         r_src_a      <= w_src_a;
         r_src_b      <= w_src_b;
         r_store_data <= w_src_fwd[1];
         r_operation  <= OPCODE_LENGTH'(w_dec_op);
         r_rd         <= rd_addr;
         r_regwrite   <= w_regwrite;
         r_is_branch  <= w_dec_is_branch;
         r_illegal    <= w_dec_illegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid     = r_valid;
   assign SrcA          = r_src_a;
   assign SrcB          = r_src_b;
   assign store_data    = r_store_data;
   assign Operation     = r_operation;
   assign out_rd        = r_rd;
   assign out_regwrite  = r_regwrite;
   assign out_is_branch = r_is_branch;
   assign illegal       = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage: a table of hand-computed
// vectors, hand-written stall/flush/reset sequences, and a randomized
// phase checked against a behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, out_rd;
   logic [31:0] rs1_data, rs2_data, imm, pc, exmem_result, memwb_result;
   logic        exmem_regwrite, memwb_regwrite;
   logic [31:0] SrcA, SrcB, store_data;
   logic [3:0]  Operation;
   logic        out_regwrite, out_is_branch, illegal;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
      .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .store_data(store_data),
      .out_rd(out_rd), .out_regwrite(out_regwrite), .out_is_branch(out_is_branch),
      .illegal(illegal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [6:0]  opc;  logic [2:0] f3;  logic f7;
      logic [4:0]  rs1a, rs2a, rd;
      logic [31:0] rs1d, rs2d, imm, pc;
      logic        exw;  logic [4:0] exrd; logic [31:0] exres;
      logic        mww;  logic [4:0] mwrd; logic [31:0] mwres;
      logic [3:0]  e_op; logic [31:0] e_a, e_b, e_sd;
      logic        e_rw, e_br, e_ill;
   } vec_t;

   function automatic vec_t mk(
      logic [6:0] opc, logic [2:0] f3, logic f7,
      logic [4:0] rs1a, logic [4:0] rs2a, logic [4:0] rd,
      logic [31:0] rs1d, logic [31:0] rs2d, logic [31:0] im, logic [31:0] p,
      logic exw, logic [4:0] exrd, logic [31:0] exres,
      logic mww, logic [4:0] mwrd, logic [31:0] mwres,
      logic [3:0] e_op, logic [31:0] e_a, logic [31:0] e_b, logic [31:0] e_sd,
      logic e_rw, logic e_br, logic e_ill);
      vec_t v;
      v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1a = rs1a; v.rs2a = rs2a; v.rd = rd;
      v.rs1d = rs1d; v.rs2d = rs2d; v.imm = im; v.pc = p;
      v.exw = exw; v.exrd = exrd; v.exres = exres;
      v.mww = mww; v.mwrd = mwrd; v.mwres = mwres;
      v.e_op = e_op; v.e_a = e_a; v.e_b = e_b; v.e_sd = e_sd;
      v.e_rw = e_rw; v.e_br = e_br; v.e_ill = e_ill;
      return v;
   endfunction

   localparam int NVEC = 16;
   vec_t vecs [NVEC];

   task automatic drive_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2);
      opcode = opc; funct3 = f3; funct7_5 = f7;
      rs1_addr = a1; rs2_addr = a2; rd_addr = rd;
      rs1_data = d1; rs2_data = d2; imm = 32'h0; pc = 32'h0;
      exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
      memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
   endtask

   task automatic apply_vec(input vec_t v);
      opcode = v.opc; funct3 = v.f3; funct7_5 = v.f7;
      rs1_addr = v.rs1a; rs2_addr = v.rs2a; rd_addr = v.rd;
      rs1_data = v.rs1d; rs2_data = v.rs2d; imm = v.imm; pc = v.pc;
      exmem_regwrite = v.exw; exmem_rd = v.exrd; exmem_result = v.exres;
      memwb_regwrite = v.mww; memwb_rd = v.mwrd; memwb_result = v.mwres;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [3:0] op; int asel; int bsel; logic rw; logic br; logic ill;
   } dec_t;

   typedef struct {
      logic valid; logic [31:0] a, b, sd; logic [3:0] op; logic [4:0] rd;
      logic rw, br, ill;
   } st_t;

   // asel: 0 rs1, 1 pc, 2 zero.  bsel: 0 rs2, 1 imm, 2 four.
   function automatic dec_t model_dec(logic [6:0] opc, logic [2:0] f3, logic f7, logic [4:0] rd);
      dec_t d;
      logic [31:0] arith_tbl;
      logic [31:0] br_tbl;
      logic        reg_form;
      arith_tbl = 32'h0153FC42;  // nibble n = operation for funct3 n
      br_tbl    = 32'hFFA9FFB8;
      d.op = 4'hF; d.asel = 0; d.bsel = 0; d.rw = 1'b0; d.br = 1'b0; d.ill = 1'b1;
      if (opc == 7'b0110011 || opc == 7'b0010011) begin
         reg_form = (opc == 7'b0110011);
         d.op = arith_tbl[f3*4 +: 4];
         if (f3 == 3'd0 && reg_form && f7) d.op = 4'h6;
         if (f3 == 3'd5 && f7) d.op = 4'h7;
         if (f3 == 3'd1 && !reg_form && f7) d.op = 4'hF;
         d.ill  = (d.op == 4'hF);
         d.rw   = !d.ill && rd != 0;
         d.bsel = reg_form ? 0 : 1;
      end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
         d.op = 4'h2; d.ill = 1'b0; d.bsel = 1;
         d.rw = (opc == 7'b0000011) && rd != 0;
      end else if (opc == 7'b1100011) begin
         d.op  = br_tbl[f3*4 +: 4];
         d.ill = (d.op == 4'hF);
         d.br  = !d.ill;
      end else if (opc == 7'b1101111 || opc == 7'b1100111) begin
         d.op = 4'h2; d.ill = 1'b0; d.asel = 1; d.bsel = 2; d.rw = rd != 0;
      end else if (opc == 7'b0110111) begin
         d.op = 4'h2; d.ill = 1'b0; d.asel = 2; d.bsel = 1; d.rw = rd != 0;
      end else if (opc == 7'b0010111) begin
         d.op = 4'h2; d.ill = 1'b0; d.asel = 1; d.bsel = 1; d.rw = rd != 0;
      end
      return d;
   endfunction

   function automatic logic [31:0] model_fwd(logic [4:0] a, logic [31:0] rf);
      if (a != 0 && exmem_regwrite && exmem_rd == a) return exmem_result;
      if (a != 0 && memwb_regwrite && memwb_rd == a) return memwb_result;
      return rf;
   endfunction

   function automatic st_t model_capture();
      st_t s;
      dec_t d;
      logic [31:0] r1, r2;
      d  = model_dec(opcode, funct3, funct7_5, rd_addr);
      r1 = model_fwd(rs1_addr, rs1_data);
      r2 = model_fwd(rs2_addr, rs2_data);
      s.valid = 1'b1;
      s.op = d.op;
      s.a  = (d.asel == 1) ? pc : (d.asel == 2) ? 32'h0 : r1;
      s.b  = (d.bsel == 1) ? imm : (d.bsel == 2) ? 32'd4 : r2;
      s.sd = r2; s.rd = rd_addr; s.rw = d.rw; s.br = d.br; s.ill = d.ill;
      return s;
   endfunction

   task automatic compare_state(input st_t m, input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m.valid));
      chk({tag, ".Operation"}, 32'(Operation), 32'(m.op));
      chk({tag, ".store_data"}, store_data, m.sd);
      chk({tag, ".out_rd"}, 32'(out_rd), 32'(m.rd));
      chk({tag, ".out_regwrite"}, 32'(out_regwrite), 32'(m.rw));
      chk({tag, ".out_is_branch"}, 32'(out_is_branch), 32'(m.br));
      chk({tag, ".illegal"}, 32'(illegal), 32'(m.ill));
      // operand routing for an illegal encoding is left undefined
      if (!m.ill) begin
         chk({tag, ".SrcA"}, SrcA, m.a);
         chk({tag, ".SrcB"}, SrcB, m.b);
      end
   endtask

   logic [6:0] opc_list [11];
   st_t        m;
   st_t        zero_st;

   initial begin
      opc_list = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
      zero_st = '{valid: 1'b0, a: 32'h0, b: 32'h0, sd: 32'h0, op: 4'h0, rd: 5'h0,
                  rw: 1'b0, br: 1'b0, ill: 1'b0};

      //               opc         f3    f7  rs1 rs2 rd  rs1d          rs2d          imm           pc            exw exrd  exres         mww mwrd  mwres         op    a             b             sd            rw br il
      vecs[0]  = mk(7'b0110011, 3'd0, 1, 1,  2,  3,  32'd10,       32'd3,        32'h0,        32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'h6, 32'd10,       32'd3,        32'd3,        1, 0, 0);
      vecs[1]  = mk(7'b0010011, 3'd0, 0, 5,  0,  6,  32'd55,       32'h0,        32'hFFFFFFFC, 32'h0,        1, 5'd5,  32'd100,      1, 5'd5,  32'd7,        4'h2, 32'd100,      32'hFFFFFFFC, 32'h0,        1, 0, 0);
      vecs[2]  = mk(7'b1100011, 3'd5, 0, 3,  4,  0,  32'd30,       32'd40,       32'h0,        32'h0,        0, 5'd0,  32'h0,        1, 5'd0,  32'd99,       4'hA, 32'd30,       32'd40,       32'd40,       0, 1, 0);
      vecs[3]  = mk(7'b0001111, 3'd0, 0, 1,  2,  7,  32'd1,        32'd2,        32'h0,        32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'hF, 32'd0,        32'd0,        32'd2,        0, 0, 1);
      vecs[4]  = mk(7'b0110111, 3'd0, 0, 3,  0,  8,  32'd77,       32'h0,        32'h12345000, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'h2, 32'h0,        32'h12345000, 32'h0,        1, 0, 0);
      vecs[5]  = mk(7'b0010111, 3'd0, 0, 0,  0,  9,  32'h0,        32'h0,        32'd2000,     32'd1000,     0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'h2, 32'd1000,     32'd2000,     32'h0,        1, 0, 0);
      vecs[6]  = mk(7'b1101111, 3'd0, 0, 0,  0,  1,  32'h0,        32'h0,        32'h100,      32'h40,       0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'h2, 32'h40,       32'd4,        32'h0,        1, 0, 0);
      vecs[7]  = mk(7'b1100111, 3'd0, 0, 2,  0,  0,  32'h8,        32'h0,        32'h4,        32'h80,       0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'h2, 32'h80,       32'd4,        32'h0,        0, 0, 0);
      vecs[8]  = mk(7'b0100011, 3'd2, 0, 10, 11, 4,  32'h100,      32'h5,        32'h8,        32'h0,        1, 5'd12, 32'h1,        1, 5'd11, 32'hDEADBEEF, 4'h2, 32'h100,      32'h8,        32'hDEADBEEF, 0, 0, 0);
      vecs[9]  = mk(7'b0000011, 3'd2, 0, 12, 0,  12, 32'h3,        32'h0,        32'h10,       32'h0,        1, 5'd12, 32'h2000,     0, 5'd0,  32'h0,        4'h2, 32'h2000,     32'h10,       32'h0,        1, 0, 0);
      vecs[10] = mk(7'b0110011, 3'd3, 0, 1,  2,  3,  32'd1,        32'd2,        32'h0,        32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'hF, 32'h0,        32'h0,        32'd2,        0, 0, 1);
      vecs[11] = mk(7'b0010011, 3'd1, 1, 1,  0,  3,  32'd1,        32'd0,        32'h401,      32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'hF, 32'h0,        32'h0,        32'd0,        0, 0, 1);
      vecs[12] = mk(7'b0010011, 3'd5, 1, 1,  0,  3,  32'h80000000, 32'd0,        32'h403,      32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'h7, 32'h80000000, 32'h403,      32'd0,        1, 0, 0);
      vecs[13] = mk(7'b1100011, 3'd2, 0, 1,  2,  0,  32'd1,        32'd2,        32'h0,        32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        4'hF, 32'h0,        32'h0,        32'd2,        0, 0, 1);
      vecs[14] = mk(7'b0110011, 3'd2, 0, 6,  7,  13, 32'd5,        32'd6,        32'h0,        32'h0,        1, 5'd7,  32'd70,       1, 5'd6,  32'd60,       4'hC, 32'd60,       32'd70,       32'd70,       1, 0, 0);
      vecs[15] = mk(7'b0110011, 3'd0, 0, 0,  0,  14, 32'h0,        32'h0,        32'h0,        32'h0,        1, 5'd0,  32'd55,       1, 5'd0,  32'd66,       4'h2, 32'h0,        32'h0,        32'h0,        1, 0, 0);

      // ---------------- reset ----------------
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive_instr(7'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      compare_state(zero_st, "reset");
      chk("reset.in_ready", 32'(in_ready), 32'd1);

      // ---------------- table vectors (back-to-back) ----------------
      for (int i = 0; i < NVEC; i++) begin
         st_t e;
         apply_vec(vecs[i]);
         in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         e = '{valid: 1'b1, a: vecs[i].e_a, b: vecs[i].e_b, sd: vecs[i].e_sd, op: vecs[i].e_op,
               rd: vecs[i].rd, rw: vecs[i].e_rw, br: vecs[i].e_br, ill: vecs[i].e_ill};
         compare_state(e, $sformatf("vec%0d", i));
         $display("vec %0d opc=%b f3=%0d Operation=%h SrcA=%h SrcB=%h", i, vecs[i].opc, vecs[i].f3, Operation, SrcA, SrcB);
      end
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("drain.out_valid", 32'(out_valid), 32'd0);

      // ---------------- stall: SLL held, XOR waiting ----------------
      drive_instr(7'b0110011, 3'd1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h2);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      drive_instr(7'b0110011, 3'd4, 1'b0, 5'd4, 5'd5, 5'd6, 32'h55, 32'h66);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall.in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
         chk("stall.out_valid", 32'(out_valid), 32'd1);
         chk("stall.Operation", 32'(Operation), 32'h4);
         chk("stall.SrcA", SrcA, 32'h11);
         chk("stall.SrcB", SrcB, 32'h2);
      end
      $display("stall held SLL for 3 cycles");
      out_ready = 1'b1;
      #1;
      chk("unstall.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("unstall.out_valid", 32'(out_valid), 32'd1);
      chk("unstall.Operation", 32'(Operation), 32'h3);
      chk("unstall.SrcA", SrcA, 32'h55);
      chk("unstall.SrcB", SrcB, 32'h66);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("xfer.out_valid", 32'(out_valid), 32'd0);

      // ---------------- flush while holding BEQ ----------------
      drive_instr(7'b1100011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h9, 32'h9);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0; flush = 1'b1;
      drive_instr(7'b0110011, 3'd0, 1'b0, 5'd3, 5'd4, 5'd5, 32'h77, 32'h1);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush.out_valid", 32'(out_valid), 32'd0);
      chk("flush.Operation", 32'(Operation), 32'h8);
      chk("flush.SrcA", SrcA, 32'h9);
      out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("flush.dropped", 32'(out_valid), 32'd0);
      end
      $display("flush dropped incoming ADD");

      // ---------------- reset mid-stall ----------------
      drive_instr(7'b0110011, 3'd6, 1'b0, 5'd1, 5'd2, 5'd5, 32'hF0, 32'h0F);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("prereset.out_valid", 32'(out_valid), 32'd1);
      chk("prereset.out_rd", 32'(out_rd), 32'd5);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      compare_state(zero_st, "midreset");
      @(posedge clk);
      @(negedge clk);
      chk("postreset.out_valid", 32'(out_valid), 32'd0);
      $display("reset mid-stall cleared stage");

      // ---------------- randomized against the model ----------------
      m = zero_st;
      for (int it = 0; it < 400; it++) begin
         logic exp_ready;
         logic [4:0] pick;
         compare_state(m, $sformatf("rnd%0d", it));
         pick = 5'($urandom_range(0, 11));
         opcode   = (pick == 5'd11) ? 7'($urandom) : opc_list[pick];
         funct3   = 3'($urandom); funct7_5 = 1'($urandom);
         rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
         rd_addr  = 5'($urandom_range(0, 7));
         rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
         exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
         memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         #1;
         exp_ready = !m.valid || out_ready;
         chk("rnd.in_ready", 32'(in_ready), 32'(exp_ready));
         if (flush) begin
            m.valid = 1'b0;
         end else if (in_valid && exp_ready) begin
            m = model_capture();
            $display("txn %0d opc=%b f3=%0d expected Operation=%h", it, opcode, funct3, m.op);
         end else if (m.valid && out_ready) begin
            m.valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      compare_state(m, "rnd_final");
      flush = 1'b0; in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage that drives the ALU: decodes RV32I opcode/funct fields into the 4-bit ALU operation code, selects and forwards SrcA/SrcB, and holds them in a single-entry pipeline register. It has a valid/ready handshake on both sides, plus flush for branch mispredicts. It sits between decode and the combinational ALU; ALU inputs come directly from its registered outputs.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1  upstream handshake
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7_5  in  1  instruction[30]
- rs1_addr, rs2_addr, rd_addr  in  REG_ADDR_WIDTH  register indices
- rs1_data, rs2_data, imm, pc  in  DATA_WIDTH  register-file reads, sign-extended immediate, instruction PC
- exmem_regwrite, memwb_regwrite  in  1  younger/older writeback enables
- exmem_rd, memwb_rd  in  REG_ADDR_WIDTH  their destinations
- exmem_result, memwb_result  in  DATA_WIDTH  their values
- flush  in  1  kill held and incoming instruction
- out_valid / out_ready  out / in  1  downstream handshake
- SrcA, SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation code
- store_data  out  DATA_WIDTH  forwarded rs2 value
- out_rd  out  REG_ADDR_WIDTH  destination register
- out_regwrite, out_is_branch, illegal  out  1  status flags

## Operation
- Operation codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, BEQ 1000, BLT 1001, BGE 1010, BNE 1011, SLT 1100, ILLEGAL 1111.
  - The ALU returns 0 for ILLEGAL.
- R-type (0110011) funct3 decode:
  - 000: ADD, or SUB when funct7_5=1.
  - 111 AND, 110 OR, 100 XOR, 001 SLL, 010 SLT.
  - 101: SRL, or SRA when funct7_5=1.
  - 011 is illegal.
  - Operands: SrcA=rs1, SrcB=rs2.
- I-ALU (0010011): same funct3 map without SUB.
  - 001 requires funct7_5=0, otherwise illegal.
  - Operands: SrcA=rs1, SrcB=imm.
- Load (0000011) and store (0100011): ADD, rs1 + imm.
- Branch (1100011): 000 BEQ, 001 BNE, 100 BLT, 101 BGE; others illegal.
  - Operands: rs1, rs2.
  - out_is_branch=1.
- JAL (1101111) and JALR (1100111): ADD with SrcA=pc, SrcB=4 (link value).
- LUI (0110111): ADD with SrcA=0, SrcB=imm.
- AUIPC (0010111): ADD with SrcA=pc, SrcB=imm.
- Any other opcode: illegal=1, Operation=1111, out_regwrite=0.
- out_regwrite=1 for R, I-ALU, load, JAL, JALR, LUI, AUIPC when rd_addr≠0. It is 0 otherwise.
- Forwarding, evaluated per source register:
  - EX/MEM wins over MEM/WB. MEM/WB wins over the register-file value.
  - A match requires regwrite=1 and rd equal to the source address, with rd≠0.
  - x0 never forwards.
  - store_data always carries the forwarded rs2.

## Timing
- Latency is one cycle: outputs are registered and change only at the rising edge of clk.
- in_ready = !out_valid || out_ready (combinational).
- Capture happens when in_valid && in_ready.
  - The stage loads decoded outputs and sets out_valid=1.
  - Forwarding inputs are sampled in the capture cycle.
- Transfer happens when out_valid && out_ready.
  - With no capture in the same cycle, out_valid goes to 0.
  - Capture and transfer in the same cycle: new data loads, out_valid stays 1 (full throughput).
- When out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
- flush takes priority over everything:
  - Next cycle out_valid=0.
  - The incoming instruction is dropped even if in_valid=1.
  - Data fields hold their last value.
- reset takes priority over flush. Next cycle every output is 0:
  - out_valid, SrcA, SrcB, Operation=0000, store_data, out_rd, out_regwrite, out_is_branch, illegal.
  - Reset mid-stall discards the held instruction.

## Structure
- Shared package alu_pkg holds:
  - the typedef enum logic [3:0] alu_op_t with the codes above;
  - the opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
- One combinational sub-module, alu_op_decoder: opcode/funct3/funct7_5 → Operation, operand selects, regwrite, is_branch, illegal.
- Forwarding muxes and the pipeline register live in the top module.

## Test plan
- After reset, R-type SUB with rs1=x1=10 and rs2=x2=3, no forwarding → one cycle later: out_valid=1, Operation=0110, SrcA=10, SrcB=3, out_regwrite=1.
- ADDI with rs1=x5, imm=-4, exmem_regwrite=1, exmem_rd=5, exmem_result=100, memwb also targeting x5 with 7 → SrcA=100, SrcB=0xFFFFFFFC, Operation=0010.
- BGE x3,x4 with memwb_rd=0 and memwb_regwrite=1 (x0 write) → no forward, Operation=1010, out_is_branch=1, out_regwrite=0.
- out_ready=0 for 3 cycles while holding SLL, with in_valid=1 carrying XOR → in_ready=0 and outputs stable. On out_ready=1 the next edge loads XOR (0011).
- flush and in_valid asserted together while holding BEQ → next cycle out_valid=0, and the incoming instruction never appears.
- opcode 0001111 → illegal=1, Operation=1111, out_regwrite=0. reset asserted mid-stall → all outputs 0 next cycle.
